// File: rtl/branch_predictor_pkg.sv
// Shared types for the dual-slot BTB branch predictor.
// Counter encoding, BTB entry layout and counter saturation.
`ifndef ALEN
`define ALEN 32
`endif

package branch_predictor_pkg;

    localparam int ALEN  = `ALEN;
    // Widest tag, reached at the smallest legal table (4 entries)
    localparam int TAG_W = ALEN - 3;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ALEN-1:0]   target;
        ctr_t              ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        unique case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btb_read_port.sv
// Single-slot BTB lookup: tag compare and per-slot prediction.
// Pure combinational, one instance per fetch slot.
module btb_read_port
    import branch_predictor_pkg::*;
#(
    parameter int IDXW = 4
) (
    input  btb_entry_t        entry,
    input  logic [`ALEN-1:0]  pc,
    output logic              hit,
    output logic              taken,
    output logic [1:0]        ctr,
    output logic [`ALEN-1:0]  target
);

    logic [TAG_W-1:0] tag;

    assign tag    = TAG_W'(pc >> (IDXW + 1));
    assign hit    = entry.valid && (entry.tag == tag);
    assign taken  = hit && entry.ctr[1];
    assign ctr    = entry.ctr;
    assign target = entry.target;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, two lookups per cycle.
// Lookups read the table combinationally; updates land at the clock edge.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0][`ALEN-1:0]  fetch_pc,
    output logic [1:0]             bp_hit,
    output logic [1:0]             bp_taken,
    output logic [1:0]             bp_state,
    output logic [`ALEN-1:0]       bp_addr,
    input  logic                   upd_valid,
    input  logic [`ALEN-1:0]       upd_pc,
    input  logic [`ALEN-1:0]       upd_target,
    input  logic                   upd_taken,
    input  logic                   upd_hit,
    input  logic [1:0]             upd_state,
    input  logic                   bp_flush
);

    localparam int IDXW = $clog2(BTB_ENTRIES);

    btb_entry_t       tbl [BTB_ENTRIES];
    logic [1:0]       slot_ctr [2];
    logic [`ALEN-1:0] slot_tgt [2];

    for (genvar s = 0; s < 2; s++) begin : g_slot
        btb_read_port #(.IDXW(IDXW)) u_rd (
            .entry  (tbl[fetch_pc[s][IDXW:1]]),
            .pc     (fetch_pc[s]),
            .hit    (bp_hit[s]),
            .taken  (bp_taken[s]),
            .ctr    (slot_ctr[s]),
            .target (slot_tgt[s])
        );
    end

    assign bp_addr  = bp_taken[0] ? slot_tgt[0] :
                      bp_taken[1] ? slot_tgt[1] : '0;
    assign bp_state = bp_hit[0] ? slot_ctr[0] :
                      bp_hit[1] ? slot_ctr[1] : 2'b01;

    logic [IDXW-1:0]  u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_match;

    assign u_idx = upd_pc[IDXW:1];
    assign u_tag = TAG_W'(upd_pc >> (IDXW + 1));
    // A stale hit (entry evicted since lookup) falls back to the miss path
    assign u_match = upd_hit && tbl[u_idx].valid && (tbl[u_idx].tag == u_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (bp_flush) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tbl[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (u_match) begin
                tbl[u_idx].ctr <= ctr_next(ctr_t'(upd_state), upd_taken);
                if (upd_taken) begin
                    tbl[u_idx].target <= upd_target;
                end
            end else if (upd_taken) begin
                tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: WT};
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for the dual-slot BTB predictor.
// Expected lookup results are queued on drive and popped on sample.
`ifndef ALEN
`define ALEN 32
`endif

module tb_branch_predictor;

    typedef struct {
        logic [1:0]       hit;
        logic [1:0]       taken;
        logic [`ALEN-1:0] addr;
        logic [1:0]       state;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [1:0][`ALEN-1:0] fetch_pc;
    logic [1:0]            bp_hit;
    logic [1:0]            bp_taken;
    logic [1:0]            bp_state;
    logic [`ALEN-1:0]      bp_addr;
    logic                  upd_valid;
    logic [`ALEN-1:0]      upd_pc;
    logic [`ALEN-1:0]      upd_target;
    logic                  upd_taken;
    logic                  upd_hit;
    logic [1:0]            upd_state;
    logic                  bp_flush;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    branch_predictor #(.BTB_ENTRIES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_pc   (fetch_pc),
        .bp_hit     (bp_hit),
        .bp_taken   (bp_taken),
        .bp_state   (bp_state),
        .bp_addr    (bp_addr),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .upd_hit    (upd_hit),
        .upd_state  (upd_state),
        .bp_flush   (bp_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, got hit=%b exp entry", tag, bp_hit);
            return;
        end
        e = exp_q.pop_front();
        assert (bp_hit === e.hit) else begin
            fails++;
            $error("FAIL %s.hit got %b exp %b", tag, bp_hit, e.hit);
        end
        tests++;
        assert (bp_taken === e.taken) else begin
            fails++;
            $error("FAIL %s.taken got %b exp %b", tag, bp_taken, e.taken);
        end
        tests++;
        assert (bp_addr === e.addr) else begin
            fails++;
            $error("FAIL %s.addr got %h exp %h", tag, bp_addr, e.addr);
        end
        tests++;
        assert (bp_state === e.state) else begin
            fails++;
            $error("FAIL %s.state got %b exp %b", tag, bp_state, e.state);
        end
    endtask

    task automatic look_now(input string tag, input logic [`ALEN-1:0] pc,
                            input logic [1:0] eh, input logic [1:0] et,
                            input logic [`ALEN-1:0] ea, input logic [1:0] es);
        exp_t e;
        fetch_pc[0] = pc;
        fetch_pc[1] = pc + 2;
        e.hit = eh; e.taken = et; e.addr = ea; e.state = es;
        exp_q.push_back(e);
        #1;
        check(tag);
    endtask

    task automatic look(input string tag, input logic [`ALEN-1:0] pc,
                        input logic [1:0] eh, input logic [1:0] et,
                        input logic [`ALEN-1:0] ea, input logic [1:0] es);
        @(negedge clk);
        look_now(tag, pc, eh, et, ea, es);
    endtask

    task automatic set_upd(input logic [`ALEN-1:0] pc, input logic [`ALEN-1:0] tgt,
                           input logic tk, input logic ht, input logic [1:0] st);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        upd_hit    = ht;
        upd_state  = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        bp_flush  = 1'b0;
    endtask

    task automatic upd(input logic [`ALEN-1:0] pc, input logic [`ALEN-1:0] tgt,
                       input logic tk, input logic ht, input logic [1:0] st);
        @(negedge clk);
        set_upd(pc, tgt, tk, ht, st);
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        bp_flush    = 1'b0;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_target  = '0;
        upd_taken   = 1'b0;
        upd_hit     = 1'b0;
        upd_state   = 2'b00;
        fetch_pc[0] = 32'h0100;
        fetch_pc[1] = 32'h0102;

        look("in_reset", 32'h0100, 2'b00, 2'b00, 32'h0, 2'b01);
        @(negedge clk);
        rst_n = 1'b1;
        look("post_reset", 32'h0100, 2'b00, 2'b00, 32'h0, 2'b01);

        // Same-cycle lookup sees pre-update contents
        @(negedge clk);
        set_upd(32'h0100, 32'h0200, 1'b1, 1'b0, 2'b01);
        look_now("same_cycle", 32'h0100, 2'b00, 2'b00, 32'h0, 2'b01);
        tick();
        look("alloc", 32'h0100, 2'b01, 2'b01, 32'h0200, 2'b10);

        upd(32'h0100, 32'h0200, 1'b0, 1'b1, 2'b10);
        look("dec_nt", 32'h0100, 2'b01, 2'b00, 32'h0, 2'b01);

        upd(32'h0100, 32'h0300, 1'b1, 1'b0, 2'b01);
        upd(32'h0102, 32'h0400, 1'b1, 1'b0, 2'b01);
        look("both_taken", 32'h0100, 2'b11, 2'b11, 32'h0300, 2'b10);
        look("slot0_0102", 32'h0102, 2'b01, 2'b01, 32'h0400, 2'b10);

        upd(32'h0100, 32'h0300, 1'b1, 1'b1, 2'b11);
        look("sat_up", 32'h0100, 2'b11, 2'b11, 32'h0300, 2'b11);
        upd(32'h0100, 32'h0500, 1'b1, 1'b1, 2'b10);
        look("inc_tgt", 32'h0100, 2'b11, 2'b11, 32'h0500, 2'b11);
        upd(32'h0102, 32'h0dead, 1'b0, 1'b1, 2'b00);
        look("sat_down", 32'h0102, 2'b01, 2'b00, 32'h0, 2'b00);

        // 0x0140 shares index 0 with 0x0100 under a new tag
        upd(32'h0140, 32'h0600, 1'b1, 1'b0, 2'b01);
        look("evicted", 32'h0100, 2'b10, 2'b00, 32'h0, 2'b00);
        look("new_occ", 32'h0140, 2'b01, 2'b01, 32'h0600, 2'b10);
        upd(32'h0100, 32'h0700, 1'b1, 1'b1, 2'b11);
        look("stale_alloc", 32'h0100, 2'b11, 2'b01, 32'h0700, 2'b10);
        look("stale_gone", 32'h0140, 2'b00, 2'b00, 32'h0, 2'b01);
        upd(32'h0140, 32'h0abc, 1'b0, 1'b1, 2'b11);
        look("stale_nt", 32'h0140, 2'b00, 2'b00, 32'h0, 2'b01);

        // Index 15 paired with index 0
        upd(32'h00fe, 32'h0800, 1'b1, 1'b0, 2'b01);
        look("wrap", 32'h00fe, 2'b11, 2'b11, 32'h0800, 2'b10);
        upd(32'h00fe, 32'h0800, 1'b0, 1'b1, 2'b10);
        look("wrap_slot1", 32'h00fe, 2'b11, 2'b10, 32'h0700, 2'b01);

        @(negedge clk);
        set_upd(32'h0180, 32'h0900, 1'b1, 1'b0, 2'b01);
        bp_flush = 1'b1;
        tick();
        look("flush_0100", 32'h0100, 2'b00, 2'b00, 32'h0, 2'b01);
        look("flush_0180", 32'h0180, 2'b00, 2'b00, 32'h0, 2'b01);
        look("flush_00fe", 32'h00fe, 2'b00, 2'b00, 32'h0, 2'b01);

        upd(32'h0100, 32'h0900, 1'b1, 1'b0, 2'b01);
        look("realloc", 32'h0100, 2'b01, 2'b01, 32'h0900, 2'b10);

        // Async reset between edges, held across an in-flight update
        @(negedge clk);
        set_upd(32'h0140, 32'h0a00, 1'b1, 1'b0, 2'b01);
        #2;
        rst_n = 1'b0;
        look_now("async_rst", 32'h0100, 2'b00, 2'b00, 32'h0, 2'b01);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        look("rst_discard", 32'h0140, 2'b00, 2'b00, 32'h0, 2'b01);
        look("rst_0100", 32'h0100, 2'b00, 2'b00, 32'h0, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries; SHALL be a power of two, minimum 4.
REQ-002 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port fetch_pc  input  [1:0][`ALEN-1:0]  lookup addresses from fetch; slot1 = slot0 + 2.
REQ-005 Port bp_hit  output  [1:0]  per-slot valid tag match.
REQ-006 Port bp_taken  output  [1:0]  per-slot taken prediction.
REQ-007 Port bp_state  output  [1:0]  counter value carried in the packet for later update.
REQ-008 Port bp_addr  output  `ALEN  predicted target.
REQ-009 Port upd_valid  input  1  backend resolved-branch update strobe.
REQ-010 Port upd_pc, upd_target  input  `ALEN each  resolved branch PC and actual target.
REQ-011 Port upd_taken, upd_hit  input  1 each  actual outcome; hit flag carried from lookup.
REQ-012 Port upd_state  input  2  counter value carried from lookup.
REQ-013 Port bp_flush  input  1  synchronous invalidate of the whole BTB.

Function
REQ-014 Index = pc[IDXW:1], IDXW = log2(BTB_ENTRIES); tag = pc[`ALEN-1:IDXW+1]; bit 0 ignored.
REQ-015 Lookup SHALL be combinational, zero latency, reflecting table contents as of the last clock edge.
REQ-016 bp_hit[i] = entry valid AND stored tag equals the tag of fetch_pc[i].
REQ-017 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; bp_taken[i] = bp_hit[i] AND counter[1].
REQ-018 bp_addr = slot0 target if bp_taken[0], else slot1 target if bp_taken[1], else 0.
REQ-019 bp_taken[1] SHALL be reported raw, not masked by bp_taken[0].
REQ-020 bp_state = slot0 counter if bp_hit[0], else slot1 counter if bp_hit[1], else 2'b01.
REQ-021 Update with upd_hit=1: entry counter <= saturating upd_state+1 if upd_taken, else saturating upd_state-1; 11+1 = 11, 00-1 = 00.
REQ-022 Update with upd_hit=1 and upd_taken=1: stored target <= upd_target.
REQ-023 Update with upd_hit=0 and upd_taken=1: allocate by writing valid=1, tag, target, counter=10, overwriting any occupant.
REQ-024 Update with upd_hit=0 and upd_taken=0: no table change.
REQ-025 Update with upd_hit=1 when the entry tag no longer matches (evicted): treat as upd_hit=0.
REQ-026 The update write SHALL take effect at the clock edge; a same-cycle lookup of that index returns pre-update contents.
REQ-027 bp_flush clears every valid bit at the next edge; when flush and update coincide, flush SHALL win and no allocation occurs.
REQ-028 Slot indices SHALL wrap modulo BTB_ENTRIES, so the highest index followed by index 0 forms a legal pair.

Reset
REQ-029 rst_n low SHALL immediately clear all valid bits and set all counters to 01; tags and targets need not be reset.
REQ-030 During and after reset until the first allocation: bp_hit=00, bp_taken=00, bp_addr=0, bp_state=01.
REQ-031 Reset asserted mid-update SHALL discard that update.

Structure
REQ-032 The shared package SHALL hold the counter-state typedef (SNT/WNT/WT/ST), the BTB entry struct (valid, tag, target, ctr), and the saturating-increment/decrement function.
REQ-033 One sub-module, btb_read_port, SHALL perform single-slot tag compare and outputs; it is instantiated twice.

Verification
REQ-034 Reset, then lookup 0x0100/0x0102 -> bp_hit=00, bp_taken=00, bp_addr=0, bp_state=01.
REQ-035 Update pc=0x0100, taken, target=0x0200, upd_hit=0; next cycle lookup 0x0100 -> bp_hit=01, bp_taken=01, bp_addr=0x0200, bp_state=10.
REQ-036 Update pc=0x0100 hit, not-taken, upd_state=10 -> state 01; lookup -> bp_hit=01, bp_taken=00, bp_addr=0.
REQ-037 Allocate both 0x0100 (target 0x0300) and 0x0102 (target 0x0400) -> bp_taken=11, bp_addr=0x0300; saturation: update taken with upd_state=11 -> state remains 11.
REQ-038 Allocate 0x0100, then allocate 0x0100+2*BTB_ENTRIES*2 (same index, new tag) -> lookup 0x0100 misses; a stale upd_hit=1 update to 0x0100 acts as upd_hit=0.
REQ-039 Coincident bp_flush and allocating update -> all lookups miss next cycle; asynchronous rst_n pulse between clock edges -> outputs drop to reset values immediately.
